// File: rtl/alu_add_arb.sv
// alu_add_arb: two-requester arbiter/sequencer for the shared WIDTH-bit ripple adder.
// Each operation takes two cycles: IDLE grants and registers adder inputs,
// EXEC captures the adder result and pulses the owner's done.
// Optional build macro ALU_ADD_ARB_OVF_EN adds a registered signed-overflow output ovf.
module alu_add_arb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             done0,
    output logic             done1,
    output logic             busy
`ifdef ALU_ADD_ARB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpInc = 2'b10;
    localparam logic [1:0] OpDec = 2'b11;

    typedef enum logic {StIdle, StExec} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;   // requester currently in EXEC
    logic             last_q, last_d;     // requester served most recently
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
`ifdef ALU_ADD_ARB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             grant;      // 0 = requester 0 wins, 1 = requester 1 wins
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] map_b;
    logic             map_cin;

    // Pick the winner: a lone request always wins; ties go by priority mode.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRI != 0) begin
                grant = 1'b0;
            end else begin
                grant = ~last_q;
            end
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    // Mux the winner's opcode and operands, then map the opcode onto adder b/cin.
    always_comb begin
        sel_op  = grant ? op1 : op0;
        sel_a   = grant ? a1 : a0;
        sel_b   = grant ? b1 : b0;
        map_b   = sel_b;
        map_cin = 1'b0;
        unique case (sel_op)
            OpAdd: begin
                map_b   = sel_b;
                map_cin = 1'b0;
            end
            OpSub: begin
                // Two's complement subtract: a + ~b + 1, cout = no borrow.
                map_b   = ~sel_b;
                map_cin = 1'b1;
            end
            OpInc: begin
                map_b   = '0;
                map_cin = 1'b1;
            end
            OpDec: begin
                // Adding all-ones is adding -1.
                map_b   = '1;
                map_cin = 1'b0;
            end
            default: begin
                map_b   = sel_b;
                map_cin = 1'b0;
            end
        endcase
    end

    // Next-state logic for the IDLE/EXEC sequencer and all registered outputs.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        out_d     = out_q;
        cout_d    = cout_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        busy_d    = busy_q;
`ifdef ALU_ADD_ARB_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (req0 || req1) begin
                    state_d   = StExec;
                    owner_d   = grant;
                    add_a_d   = sel_a;
                    add_b_d   = map_b;
                    add_cin_d = map_cin;
                    busy_d    = 1'b1;
                end
            end
            StExec: begin
                // Adder is combinational from the registered inputs; capture it now.
                out_d   = add_sum;
                cout_d  = add_cout;
`ifdef ALU_ADD_ARB_OVF_EN
                ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != add_a_q[WIDTH-1]);
`endif
                done0_d = ~owner_q;
                done1_d = owner_q;
                last_d  = owner_q;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            out_q     <= '0;
            cout_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ALU_ADD_ARB_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            out_q     <= out_d;
            cout_q    <= cout_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
`ifdef ALU_ADD_ARB_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign out     = out_q;
    assign cout    = cout_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign busy    = busy_q;
`ifdef ALU_ADD_ARB_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_alu_add_arb.sv
// Testbench for alu_add_arb: directed vector table, hand sequences for fairness,
// drop-during-EXEC and reset-during-EXEC, plus random ops against an arithmetic model.
module tb_alu_add_arb;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpInc = 2'b10;
    localparam logic [1:0] OpDec = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic [7:0] add_a, add_b, add_sum, out;
    logic       add_cin, add_cout, cout, done0, done1, busy;
    logic       ovf_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Environment model of the shared ripple adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    alu_add_arb #(.WIDTH(8), .FIXED_PRI(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .op0      (op0),
        .a0       (a0),
        .b0       (b0),
        .req1     (req1),
        .op1      (op1),
        .a1       (a1),
        .b1       (b1),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .out      (out),
        .cout     (cout),
        .done0    (done0),
        .done1    (done1),
        .busy     (busy)
`ifdef ALU_ADD_ARB_OVF_EN
        ,
        .ovf      (ovf_w)
`endif
    );

`ifndef ALU_ADD_ARB_OVF_EN
    assign ovf_w = 1'b0;
`endif

    typedef struct {
        int         who;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Plain integer arithmetic reference: unsigned result/carry and signed overflow.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] o, output logic c, output logic v);
        int ua, ub, sa, sb, u, s;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OpAdd:   begin u = ua + ub; c = (u > 255);  s = sa + sb; end
            OpSub:   begin u = ua - ub; c = (ua >= ub); s = sa - sb; end
            OpInc:   begin u = ua + 1;  c = (ua == 255); s = sa + 1; end
            default: begin u = ua - 1;  c = (ua != 0);  s = sa - 1; end
        endcase
        o = 8'(u & 255);
        v = (s > 127) || (s < -128);
    endtask

    // Issue one request from an idle DUT and wait (bounded) for its done.
    task automatic run_op(input int who, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, output logic [7:0] o, output logic c,
                          output logic v, output int lat, output logic busy1,
                          output logic other);
        bit got;
        got   = 0;
        lat   = 0;
        busy1 = 1'b0;
        other = 1'b0;
        if (who == 0) begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end
        for (int i = 1; i <= 10 && !got; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) busy1 = busy;
            if ((who == 0 && done0) || (who == 1 && done1)) begin
                got   = 1;
                lat   = i;
                other = (who == 0) ? done1 : done0;
            end
        end
        o = out;
        c = cout;
        v = ovf_w;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic do_and_check(input string tag, input int who, input logic [1:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] eo, input logic ec, input logic ev);
        logic [7:0] o;
        logic       c, v, b1, oth;
        int         lat;
        run_op(who, op, a, b, o, c, v, lat, b1, oth);
        check({tag, ".lat"}, lat, 2);
        check({tag, ".busy"}, b1, 1);
        check({tag, ".out"}, o, eo);
        check({tag, ".cout"}, c, ec);
        check({tag, ".other_done"}, oth, 0);
`ifdef ALU_ADD_ARB_OVF_EN
        check({tag, ".ovf"}, v, ev);
`else
        if (ev === 1'bx) check({tag, ".ovf_unused"}, v, 0);
`endif
    endtask

    initial begin
        logic [7:0] eo;
        logic       ec, ev;
        logic [1:0] rop;
        logic [7:0] ra, rb;
        int         rwho;

        vecs[0] = '{0, OpAdd, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{1, OpSub, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[2] = '{1, OpSub, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[3] = '{0, OpInc, 8'hFF, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{0, OpDec, 8'h00, 8'h33, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{0, OpAdd, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{1, OpAdd, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1, OpSub, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[8] = '{0, OpDec, 8'h80, 8'hC4, 8'h7F, 1'b1, 1'b1};
        vecs[9] = '{1, OpInc, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.add_a", add_a, 0);
        check("rst.add_b", add_b, 0);
        check("rst.add_cin", add_cin, 0);
        check("rst.out", out, 0);
        check("rst.cout", cout, 0);
        check("rst.done0", done0, 0);
        check("rst.done1", done1, 0);
        check("rst.busy", busy, 0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            do_and_check($sformatf("vec%0d", i), vecs[i].who, vecs[i].op, vecs[i].a,
                         vecs[i].b, vecs[i].exp_out, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Result holds while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold.out", out, 8'h80);
        check("hold.done0", done0, 0);
        check("hold.done1", done1, 0);

        // Request dropped during EXEC still completes; operand change is ignored.
        req0 = 1'b1; op0 = OpInc; a0 = 8'h41; b0 = 8'h00;
        @(posedge clk);
        #1;
        check("drop.busy", busy, 1);
        req0 = 1'b0;
        a0 = 8'h99;
        @(posedge clk);
        #1;
        check("drop.done0", done0, 1);
        check("drop.out", out, 8'h42);
        @(posedge clk);
        #1;
        check("drop.pulse_end", done0, 0);
        check("drop.busy_end", busy, 0);

        // Fairness: fresh reset, both requesters held high, expect 0,1,0,1 every 2 cycles.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0 = 1'b1; op0 = OpAdd; a0 = 8'h01; b0 = 8'h02;
        req1 = 1'b1; op1 = OpAdd; a1 = 8'h0A; b1 = 8'h14;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr%0d.done0", i), done0, (i % 4 == 2));
            check($sformatf("rr%0d.done1", i), done1, (i % 4 == 0));
            check($sformatf("rr%0d.busy", i), busy, (i % 2 == 1));
            if (i % 4 == 2) check($sformatf("rr%0d.out", i), out, 8'h03);
            if (i % 4 == 0) check($sformatf("rr%0d.out", i), out, 8'h1E);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset during EXEC of a requester-1 ADD: abandoned, outputs cleared.
        req1 = 1'b1; op1 = OpAdd; a1 = 8'h11; b1 = 8'h22;
        @(posedge clk);
        #1;
        check("rstx.busy", busy, 1);
        rst = 1'b1;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        check("rstx.done1", done1, 0);
        check("rstx.out", out, 0);
        check("rstx.cout", cout, 0);
        check("rstx.busy", busy, 0);
        check("rstx.add_a", add_a, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstx.done1_after", done1, 0);
        do_and_check("post_rst", 0, OpAdd, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            rwho = int'($urandom_range(1, 0));
            rop  = 2'($urandom_range(3, 0));
            ra   = 8'($urandom_range(255, 0));
            rb   = 8'($urandom_range(255, 0));
            model(rop, ra, rb, eo, ec, ev);
            do_and_check($sformatf("rnd%0d", i), rwho, rop, ra, rb, eo, ec, ev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_add_arb.md
Name: alu_add_arb

Overview:
- Two-requester arbiter and sequencer for the single shared 8-bit ripple adder (add8) in the ALU.
- Accepts ADD/SUB/INC/DEC requests from two clients and grants the adder round-robin.
- Drives the adder's a/b/cin inputs from registers and captures sum/carry one cycle later.
- Returns the result with a per-requester done pulse. The adder itself sits outside this block.

Parameters:
- WIDTH, 8, datapath width of operands, adder and result.
- FIXED_PRI, 0, 0 = round-robin arbitration; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high until done0.
- op0  input  2  requester 0 opcode: 00 ADD, 01 SUB, 10 INC, 11 DEC.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B; ignored for INC/DEC.
- req1, op1, a1, b1  input  1/2/WIDTH/WIDTH  requester 1, same meaning as above.
- add_a  output  WIDTH  registered drive to shared adder input a.
- add_b  output  WIDTH  registered drive to shared adder input b.
- add_cin  output  1  registered drive to shared adder cin.
- add_sum  input  WIDTH  shared adder sum (combinational from add_a/add_b/add_cin).
- add_cout  input  1  shared adder carry out.
- out  output  WIDTH  registered result of the last completed operation.
- cout  output  1  registered carry of the last operation (SUB: 1 = no borrow).
- done0  output  1  one-cycle pulse: out/cout valid for requester 0.
- done1  output  1  one-cycle pulse: out/cout valid for requester 1.
- busy  output  1  high while in EXEC.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; add_a, add_b, add_cin, out, cout, done0, done1 and busy all 0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC.
- IDLE, no request: remain in IDLE; done0 and done1 are 0.
- IDLE, at least one req high:
  - Select the winner (see Arbitration).
  - Register the winner's operands into add_a/add_b/add_cin per the opcode map.
  - Record owner; set busy=1; go to EXEC.
- Opcode map (X = winner's A, Y = winner's B):
  - ADD: add_a=X, add_b=Y, add_cin=0.
  - SUB: add_a=X, add_b=~Y, add_cin=1.
  - INC: add_a=X, add_b=0, add_cin=1.
  - DEC: add_a=X, add_b=all-ones, add_cin=0.
- EXEC, at the next edge:
  - out<=add_sum, cout<=add_cout.
  - Pulse done of the owner for exactly one cycle.
  - Set last-served=owner, busy<=0, return to IDLE.
- Latency and throughput:
  - Request seen in IDLE at edge N gives done high during cycle N+2.
  - Maximum throughput is one operation per 2 cycles.
- Arbitration:
  - FIXED_PRI=0: on simultaneous req0 and req1, grant the requester not equal to last-served.
  - FIXED_PRI=1: requester 0 always wins.
  - A lone request is always granted.
- Request protocol:
  - A requester holds req, op and operands stable until its done.
  - req still high in the cycle after done is a new request.
  - Operands are sampled only in IDLE; changes during EXEC are ignored.
- Wrap-around: result is mod 2^WIDTH; the carry appears only on cout.
  - Example: INC of FF gives out=00, cout=1.
- Between operations, out/cout hold their value; they change only at the EXEC-to-IDLE edge.
- A req that drops while its operation is in EXEC still completes, and done still pulses.
- rst during EXEC: the operation is abandoned, no done pulse, all outputs go to their reset values at that edge.

Optional Feature:
- Macro ALU_ADD_ARB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered with out.
  - ovf = signed overflow = (add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]), evaluated in EXEC.
  - ovf reset value is 0.
- Undefined: port ovf does not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then req0 ADD a0=0x3C b0=0x05 → done0 in the 2nd cycle after sampling; out=0x41, cout=0, done1 stays 0.
- req1 SUB a1=0x10 b1=0x20 → out=0xF0, cout=0 (borrow). Then SUB 0x20-0x10 → out=0x10, cout=1.
- req0 INC a0=0xFF → out=0x00, cout=1. req0 DEC a0=0x00 → out=0xFF, cout=0.
- req0 and req1 held high continuously (FIXED_PRI=0):
  - done sequence is done0, done1, done0, done1; one done every 2 cycles.
  - busy toggles 1/0.
- Assert rst in the EXEC cycle of a req1 ADD → no done1; out=0, cout=0, busy=0 next cycle. The next request is granted normally.
- With ALU_ADD_ARB_OVF_EN: ADD 0x7F+0x01 → out=0x80, ovf=1, cout=0. ADD 0xFF+0x01 → out=0x00, ovf=0, cout=1.
